// File: rtl/lsu_if.sv
// Core/memory-side signal bundle for the load/store unit.
// The slave modport is the LSU's view; the master modport is the core plus data-memory side.
interface lsu_if;
    // Execute-stage request and write-back result
    logic        ls_valid;
    logic        ls_wen;
    logic [2:0]  ls_size;
    logic [63:0] ls_addr;
    logic [63:0] ls_wdata;
    logic        ls_busy;
    logic        ls_done;
    logic        ls_err;
    logic [63:0] ls_rdata;

    // Data-memory bus
    logic        mem_req;
    logic        mem_wen;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;

    modport slave (
        input  ls_valid, ls_wen, ls_size, ls_addr, ls_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output ls_busy, ls_done, ls_err, ls_rdata,
        output mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask
    );

    modport master (
        output ls_valid, ls_wen, ls_size, ls_addr, ls_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  ls_busy, ls_done, ls_err, ls_rdata,
        input  mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one request/grant/response data-memory transaction per access,
// with lane steering for stores, sign/zero extension for loads, and a bus timeout.
module lsu #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic   clk,
    input  logic   rst,
    lsu_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t            state_reg, state_next;
    logic              wen_reg;
    logic [2:0]        size_reg;
    logic [63:0]       addr_reg;
    logic [63:0]       wdata_reg;
    logic [7:0]        wmask_reg;
    logic              err_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [63:0]       rdata_reg;

    logic              aligned;
    logic [7:0]        base_mask;
    logic [63:0]       rdata_shifted;
    logic [63:0]       load_ext;
    logic              timeout_hit;

    assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT - 1));

    // Alignment and lane mask depend only on the access width (size[1:0]); 111 falls into the d case.
    always_comb begin
        aligned   = 1'b1;
        base_mask = 8'h01;
        case (bus.ls_size[1:0])
            2'b00: begin aligned = 1'b1;                       base_mask = 8'h01; end
            2'b01: begin aligned = (bus.ls_addr[0] == 1'b0);   base_mask = 8'h03; end
            2'b10: begin aligned = (bus.ls_addr[1:0] == 2'b00); base_mask = 8'h0F; end
            default: begin aligned = (bus.ls_addr[2:0] == 3'b000); base_mask = 8'hFF; end
        endcase
    end

    assign rdata_shifted = bus.mem_rdata >> {addr_reg[2:0], 3'b000};

    always_comb begin
        load_ext = rdata_shifted;
        case (size_reg)
            3'b000:  load_ext = {{56{rdata_shifted[7]}},  rdata_shifted[7:0]};
            3'b001:  load_ext = {{48{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b010:  load_ext = {{32{rdata_shifted[31]}}, rdata_shifted[31:0]};
            3'b100:  load_ext = {56'd0, rdata_shifted[7:0]};
            3'b101:  load_ext = {48'd0, rdata_shifted[15:0]};
            3'b110:  load_ext = {32'd0, rdata_shifted[31:0]};
            default: load_ext = rdata_shifted;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic; a response arriving on the timeout cycle still completes normally.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (bus.ls_valid) state_next = aligned ? REQ : DONE;
            REQ: begin
                if (timeout_hit)      state_next = DONE;
                else if (bus.mem_gnt) state_next = WAIT;
            end
            WAIT: begin
                if (bus.mem_rvalid || timeout_hit) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Access context, timeout counter and load result
    always_ff @(posedge clk) begin
        if (rst) begin
            wen_reg   <= 1'b0;
            size_reg  <= 3'b000;
            addr_reg  <= 64'd0;
            wdata_reg <= 64'd0;
            wmask_reg <= 8'd0;
            err_reg   <= 1'b0;
            cnt_reg   <= '0;
            rdata_reg <= 64'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.ls_valid) begin
                        wen_reg   <= bus.ls_wen;
                        size_reg  <= bus.ls_size;
                        addr_reg  <= bus.ls_addr;
                        wdata_reg <= bus.ls_wen ? (bus.ls_wdata << {bus.ls_addr[2:0], 3'b000}) : 64'd0;
                        wmask_reg <= bus.ls_wen ? (base_mask << bus.ls_addr[2:0]) : 8'd0;
                        err_reg   <= ~aligned;
                        cnt_reg   <= '0;
                    end
                end
                REQ: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (timeout_hit) err_reg <= 1'b1;
                end
                WAIT: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (bus.mem_rvalid) begin
                        if (!wen_reg) rdata_reg <= load_ext;
                    end else if (timeout_hit) begin
                        err_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs: bus fields are only driven while the request is outstanding.
    always_comb begin
        bus.ls_busy   = (state_reg != IDLE);
        bus.ls_done   = (state_reg == DONE);
        bus.ls_err    = (state_reg == DONE) && err_reg;
        bus.ls_rdata  = rdata_reg;
        bus.mem_req   = 1'b0;
        bus.mem_wen   = 1'b0;
        bus.mem_addr  = 64'd0;
        bus.mem_wdata = 64'd0;
        bus.mem_wmask = 8'd0;
        if (state_reg == REQ) begin
            bus.mem_req   = 1'b1;
            bus.mem_wen   = wen_reg;
            bus.mem_addr  = {addr_reg[63:3], 3'b000};
            bus.mem_wdata = wdata_reg;
            bus.mem_wmask = wmask_reg;
        end
    end
endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed vector table, multi-cycle corner sequences,
// and randomized accesses checked against a byte-arithmetic reference model.
module tb_lsu;
    localparam int TOUT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_if bus();

    lsu #(.TIMEOUT(TOUT), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        wen;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          gnt_dly;
        int          rv_dly;     // 0 = response never arrives
        bit          rv_at_gnt;  // spurious rvalid with bad data on the grant cycle
        logic [63:0] e_rd;
        logic        e_err;
        int          e_lat;
        int          e_req;
        logic [7:0]  e_wm;
        logic [63:0] e_wd;
    } vec_t;

    vec_t tbl[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Plays core and memory for one access; returns what was observed.
    task automatic run(input vec_t v, output int lat, output logic err, output logic [63:0] rd,
                       output int req_cyc, output logic [7:0] wm, output logic [63:0] wd,
                       output logic [63:0] ma, output logic mw, output bit unstable);
        int gnt_cyc;
        bus.ls_valid = 1'b1;
        bus.ls_wen   = v.wen;
        bus.ls_size  = v.size;
        bus.ls_addr  = v.addr;
        bus.ls_wdata = v.wdata;
        bus.mem_gnt  = 1'b0;
        bus.mem_rvalid = 1'b0;
        lat = -1; err = 1'b0; rd = '0; req_cyc = 0; wm = '0; wd = '0; ma = '0; mw = 1'b0;
        unstable = 1'b0; gnt_cyc = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            // Core-side inputs wander after acceptance; they must not matter.
            bus.ls_addr  = {$urandom, $urandom};
            bus.ls_wdata = {$urandom, $urandom};
            bus.ls_wen   = 1'($urandom);
            bus.ls_size  = 3'($urandom);
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = {$urandom, $urandom};
            if (bus.ls_done) begin
                lat = c; err = bus.ls_err; rd = bus.ls_rdata;
                bus.ls_valid = 1'b0;
                break;
            end
            if (bus.mem_req) begin
                if (req_cyc == 0) begin
                    wm = bus.mem_wmask; wd = bus.mem_wdata; ma = bus.mem_addr; mw = bus.mem_wen;
                end else if (wm !== bus.mem_wmask || wd !== bus.mem_wdata ||
                             ma !== bus.mem_addr || mw !== bus.mem_wen) begin
                    unstable = 1'b1;
                end
                req_cyc++;
                if (req_cyc == v.gnt_dly + 1) begin
                    bus.mem_gnt = 1'b1;
                    gnt_cyc = c;
                    if (v.rv_at_gnt) begin
                        bus.mem_rvalid = 1'b1;
                        bus.mem_rdata  = ~v.rdata;
                    end
                end
            end
            if (gnt_cyc >= 0 && v.rv_dly > 0 && c == gnt_cyc + v.rv_dly) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = v.rdata;
            end
        end
        bus.ls_valid = 1'b0;
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b0;
    endtask

    task automatic apply(input string tag, input vec_t v);
        int lat, req_cyc;
        logic err, mw;
        logic [63:0] rd, wd, ma;
        logic [7:0] wm;
        bit unstable;
        run(v, lat, err, rd, req_cyc, wm, wd, ma, mw, unstable);
        $display("txn %s: wen=%0b size=%0d addr=%h lat=%0d err=%0b rdata=%h", tag, v.wen, v.size,
                 v.addr, lat, err, rd);
        check({tag, " latency"}, 64'(lat), 64'(v.e_lat));
        check({tag, " ls_err"}, 64'(err), 64'(v.e_err));
        check({tag, " ls_rdata"}, rd, v.e_rd);
        check({tag, " req cycles"}, 64'(req_cyc), 64'(v.e_req));
        if (v.e_req > 0) begin
            check({tag, " mem_wmask"}, 64'(wm), 64'(v.e_wm));
            check({tag, " mem_wdata"}, wd, v.e_wd);
            check({tag, " mem_addr"}, ma, v.addr & ~64'h7);
            check({tag, " mem_wen"}, 64'(mw), 64'(v.wen));
            check({tag, " bus stable"}, 64'(unstable), 64'd0);
        end
        tick();
        check({tag, " rdata held"}, bus.ls_rdata, v.e_rd);
        check({tag, " idle after done"}, {62'd0, bus.ls_busy, bus.ls_done}, 64'd0);
    endtask

    // Reference: byte arithmetic on the access width and offset.
    task automatic model(inout vec_t v, input logic [63:0] prev);
        int nb, off;
        logic [63:0] val, keep;
        nb  = 1 << v.size[1:0];
        off = int'(v.addr[2:0]);
        v.e_err = (off % nb) != 0;
        v.e_rd = prev; v.e_wm = '0; v.e_wd = '0;
        v.e_lat = v.e_err ? 1 : 2 + v.gnt_dly + v.rv_dly;
        v.e_req = v.e_err ? 0 : v.gnt_dly + 1;
        if (!v.e_err && v.wen) begin
            v.e_wm = 8'(((1 << nb) - 1) << off);
            v.e_wd = v.wdata << (8 * off);
        end
        if (!v.e_err && !v.wen) begin
            val = v.rdata >> (8 * off);
            if (nb < 8) begin
                keep = (64'd1 << (8 * nb)) - 64'd1;
                val = val & keep;
                if (!v.size[2] && val[8 * nb - 1]) val = val | ~keep;
            end
            v.e_rd = val;
        end
    endtask

    initial begin
        bit saw_done;
        logic [63:0] prev;
        vec_t v;

        //          wen   size    addr                  wdata                  rdata                  g   r  ag   e_rd                   err lat req wm     wd
        tbl[0]  = '{1'b0, 3'b010, 64'h0000_0000_8000_0004, 64'h0, 64'hF234_5678_0000_0000, 0, 1, 0, 64'hFFFF_FFFF_F234_5678, 1'b0, 3, 1, 8'h00, 64'h0};
        tbl[1]  = '{1'b0, 3'b100, 64'h0000_0000_8000_0003, 64'h0, 64'h0000_0000_AB00_0000, 3, 1, 0, 64'h0000_0000_0000_00AB, 1'b0, 6, 4, 8'h00, 64'h0};
        tbl[2]  = '{1'b1, 3'b001, 64'h0000_0000_8000_0006, 64'h1234, 64'h0,              0, 1, 0, 64'h0000_0000_0000_00AB, 1'b0, 3, 1, 8'hC0, 64'h1234_0000_0000_0000};
        tbl[3]  = '{1'b0, 3'b010, 64'h0000_0000_8000_0002, 64'h0, 64'h0,                 0, 1, 0, 64'h0000_0000_0000_00AB, 1'b1, 1, 0, 8'h00, 64'h0};
        tbl[4]  = '{1'b1, 3'b011, 64'h0000_0000_8000_0004, 64'h5, 64'h0,                 0, 1, 0, 64'h0000_0000_0000_00AB, 1'b1, 1, 0, 8'h00, 64'h0};
        tbl[5]  = '{1'b0, 3'b011, 64'h0000_0000_8000_0008, 64'h0, 64'h0123_4567_89AB_CDEF, 1, 2, 0, 64'h0123_4567_89AB_CDEF, 1'b0, 5, 2, 8'h00, 64'h0};
        tbl[6]  = '{1'b0, 3'b001, 64'h0000_0000_8000_000A, 64'h0, 64'h0000_0000_8765_0000, 0, 1, 0, 64'hFFFF_FFFF_FFFF_8765, 1'b0, 3, 1, 8'h00, 64'h0};
        tbl[7]  = '{1'b0, 3'b000, 64'h0000_0000_8000_0011, 64'h0, 64'h0000_0000_0000_8000, 2, 1, 0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 5, 3, 8'h00, 64'h0};
        tbl[8]  = '{1'b1, 3'b000, 64'h0000_0000_8000_0017, 64'hAA55, 64'h0,              0, 3, 0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 5, 1, 8'h80, 64'h5500_0000_0000_0000};
        tbl[9]  = '{1'b0, 3'b111, 64'h0000_0000_8000_0020, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 0, 1, 0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 3, 1, 8'h00, 64'h0};
        tbl[10] = '{1'b0, 3'b110, 64'h0000_0000_8000_0024, 64'h0, 64'h9000_0001_0000_0000, 0, 1, 0, 64'h0000_0000_9000_0001, 1'b0, 3, 1, 8'h00, 64'h0};
        tbl[11] = '{1'b0, 3'b010, 64'h0000_0000_8000_0000, 64'h0, 64'h1111_2222_3333_4444, 0, 0, 0, 64'h0000_0000_9000_0001, 1'b1, 9, 1, 8'h00, 64'h0};
        tbl[12] = '{1'b1, 3'b010, 64'h0000_0000_8000_0004, 64'hFFFF_FFFF_1122_3344, 64'h0, 0, 1, 0, 64'h0000_0000_9000_0001, 1'b0, 3, 1, 8'hF0, 64'h1122_3344_0000_0000};
        tbl[13] = '{1'b0, 3'b010, 64'h0000_0000_8000_0000, 64'h0, 64'h0,                20, 1, 0, 64'h0000_0000_9000_0001, 1'b1, 9, 8, 8'h00, 64'h0};
        tbl[14] = '{1'b0, 3'b010, 64'h0000_0000_8000_0000, 64'h0, 64'h0000_0000_7FFF_FFFF, 0, 2, 1, 64'h0000_0000_7FFF_FFFF, 1'b0, 4, 1, 8'h00, 64'h0};
        tbl[15] = '{1'b0, 3'b101, 64'h0000_0000_8000_000E, 64'h0, 64'h8765_0000_0000_0000, 1, 1, 0, 64'h0000_0000_0000_8765, 1'b0, 4, 2, 8'h00, 64'h0};

        bus.ls_valid = 1'b0; bus.ls_wen = 1'b0; bus.ls_size = '0; bus.ls_addr = '0; bus.ls_wdata = '0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset outputs",
              {58'd0, bus.ls_busy, bus.ls_done, bus.ls_err, bus.mem_req, bus.mem_wen, |bus.mem_wmask}, 64'd0);
        check("reset ls_rdata", bus.ls_rdata, 64'd0);
        check("reset mem_addr", bus.mem_addr | bus.mem_wdata, 64'd0);

        for (int i = 0; i < 16; i++) apply($sformatf("vec%0d", i), tbl[i]);

        // Reset while waiting for the response; the late response must be dropped.
        bus.ls_valid = 1'b1; bus.ls_wen = 1'b0; bus.ls_size = 3'b010; bus.ls_addr = 64'h8000_0004;
        tick();
        check("rstmid req", 64'(bus.mem_req), 64'd1);
        bus.ls_valid = 1'b0;
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid outputs", {60'd0, bus.ls_busy, bus.ls_done, bus.ls_err, bus.mem_req}, 64'd0);
        check("rstmid ls_rdata", bus.ls_rdata, 64'd0);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        bus.mem_rvalid = 1'b0;
        saw_done = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (bus.ls_done || bus.ls_busy) saw_done = 1'b1;
            tick();
        end
        $display("txn rstmid: late response after reset, activity=%0b", saw_done);
        check("rstmid no done", 64'(saw_done), 64'd0);
        check("rstmid rdata kept", bus.ls_rdata, 64'd0);

        prev = 64'd0;
        for (int i = 0; i < 40; i++) begin
            v.wen = 1'($urandom);
            v.size = 3'($urandom);
            v.addr = {32'h0000_0000, 32'h8000_0000 | 32'($urandom_range(0, 32'hFFFF))};
            if ($urandom_range(0, 3) != 0) v.addr = v.addr & ~((64'd1 << v.size[1:0]) - 64'd1);
            v.wdata = {$urandom, $urandom};
            v.rdata = {$urandom, $urandom};
            v.gnt_dly = $urandom_range(0, 3);
            v.rv_dly = $urandom_range(1, 3);
            v.rv_at_gnt = 1'b0;
            model(v, prev);
            apply($sformatf("rnd%0d", i), v);
            prev = v.e_rd;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
